// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter: set-mode states and BCD digit limits.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } set_state_t;

  localparam logic [3:0] ONE_MAX              = 4'd9;
  localparam logic [3:0] SEC_TEN_MAX          = 4'd5;
  localparam logic [3:0] MIN_TEN_MAX          = 4'd5;
  localparam logic [3:0] HOUR_MAX_TEN         = 4'd2;
  localparam logic [3:0] HOUR_MAX_ONE_AT_TEN2 = 4'd3;

  // Split a small binary value into its BCD tens and units digits.
  function automatic logic [3:0] tensOf(input int value);
    return 4'(value / 10);
  endfunction

  function automatic logic [3:0] onesOf(input int value);
    return 4'(value % 10);
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with enable, synchronous clear and a same-edge carry-out.
module bcd_mod60
  import clock_pkg::*;
#(
  parameter logic [3:0] RESET_ONE = 4'd0,
  parameter logic [3:0] RESET_TEN = 4'd0,
  parameter logic [3:0] TEN_MAX   = SEC_TEN_MAX
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [3:0] one_o,
  output logic [3:0] ten_o,
  output logic       carry_o
);

  logic [3:0] one_q, one_d;
  logic [3:0] ten_q, ten_d;
  logic       atMax;

  assign atMax = (one_q == ONE_MAX) && (ten_q == TEN_MAX);

  // Carry is combinational so the next stage updates in the very same edge.
  assign carry_o = en_i && !clr_i && atMax;

  always_comb begin
    one_d = one_q;
    ten_d = ten_q;
    if (clr_i) begin
      one_d = 4'd0;
      ten_d = 4'd0;
    end else if (en_i) begin
      if (one_q == ONE_MAX) begin
        one_d = 4'd0;
        ten_d = atMax ? 4'd0 : ten_q + 4'd1;
      end else begin
        one_d = one_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      one_q <= RESET_ONE;
      ten_q <= RESET_TEN;
    end else begin
      one_q <= one_d;
      ten_q <= ten_d;
    end
  end

  assign one_o = one_q;
  assign ten_o = ten_q;

endmodule

// File: rtl/time_counter.sv
// 24 h BCD time-of-day counter with hour/minute set mode, blink control and carry strobes.
module time_counter
  import clock_pkg::*;
#(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic       tick_1hz,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [3:0] sec_one,
  output logic [3:0] sec_ten,
  output logic [3:0] min_one,
  output logic [3:0] min_ten,
  output logic [3:0] hour_one,
  output logic [3:0] hour_ten,
  output logic [1:0] set_state,
  output logic       blink,
  output logic       min_strobe,
  output logic       hour_strobe
);

  if (RESET_HOUR < 0 || RESET_HOUR > 23) begin : gBadHour
    $error("time_counter: RESET_HOUR must be in 0..23");
  end
  if (RESET_MIN < 0 || RESET_MIN > 59) begin : gBadMin
    $error("time_counter: RESET_MIN must be in 0..59");
  end

  localparam logic [3:0] RST_HOUR_TEN = tensOf(RESET_HOUR);
  localparam logic [3:0] RST_HOUR_ONE = onesOf(RESET_HOUR);
  localparam logic [3:0] RST_MIN_TEN  = tensOf(RESET_MIN);
  localparam logic [3:0] RST_MIN_ONE  = onesOf(RESET_MIN);

  set_state_t state_q;
  logic       blink_q;
  logic       minStrobe_q;
  logic       hourStrobe_q;
  logic [3:0] hourOne_q, hourOne_d;
  logic [3:0] hourTen_q, hourTen_d;

  logic isRun, isSetHour, isSetMin;
  logic secEn, secClr, secCarry;
  logic minEn, minCarry;
  logic hourStep;

  assign isRun     = (state_q == RUN);
  assign isSetHour = (state_q == SET_HOUR);
  assign isSetMin  = (state_q == SET_MIN);

  // A mode pulse always wins over a simultaneous increment.
  assign secEn    = isRun && tick_1hz;
  assign secClr   = isSetMin && mode_pulse;
  assign minEn    = secCarry || (isSetMin && inc_pulse && !mode_pulse);
  assign hourStep = (isRun && minCarry) || (isSetHour && inc_pulse && !mode_pulse);

  bcd_mod60 #(
    .RESET_ONE (4'd0),
    .RESET_TEN (4'd0),
    .TEN_MAX   (SEC_TEN_MAX)
  ) uSeconds (
    .clk     (clk),
    .CLR_n   (CLR_n),
    .en_i    (secEn),
    .clr_i   (secClr),
    .one_o   (sec_one),
    .ten_o   (sec_ten),
    .carry_o (secCarry)
  );

  bcd_mod60 #(
    .RESET_ONE (RST_MIN_ONE),
    .RESET_TEN (RST_MIN_TEN),
    .TEN_MAX   (MIN_TEN_MAX)
  ) uMinutes (
    .clk     (clk),
    .CLR_n   (CLR_n),
    .en_i    (minEn),
    .clr_i   (1'b0),
    .one_o   (min_one),
    .ten_o   (min_ten),
    .carry_o (minCarry)
  );

  always_comb begin
    hourOne_d = hourOne_q;
    hourTen_d = hourTen_q;
    if (hourStep) begin
      if (hourTen_q == HOUR_MAX_TEN && hourOne_q == HOUR_MAX_ONE_AT_TEN2) begin
        hourOne_d = 4'd0;
        hourTen_d = 4'd0;
      end else if (hourOne_q == ONE_MAX) begin
        hourOne_d = 4'd0;
        hourTen_d = hourTen_q + 4'd1;
      end else begin
        hourOne_d = hourOne_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      hourOne_q <= RST_HOUR_ONE;
      hourTen_q <= RST_HOUR_TEN;
    end else begin
      hourOne_q <= hourOne_d;
      hourTen_q <= hourTen_d;
    end
  end

  // Strobes land in the same cycle as the wrapped digits; blink restarts high on each set-state entry.
  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      state_q      <= RUN;
      blink_q      <= 1'b0;
      minStrobe_q  <= 1'b0;
      hourStrobe_q <= 1'b0;
    end else begin
      minStrobe_q  <= isRun && secCarry;
      hourStrobe_q <= isRun && minCarry;
      case (state_q)
        RUN: begin
          if (mode_pulse) begin
            state_q <= SET_HOUR;
            blink_q <= 1'b1;
          end else begin
            blink_q <= 1'b0;
          end
        end
        SET_HOUR: begin
          if (mode_pulse) begin
            state_q <= SET_MIN;
            blink_q <= 1'b1;
          end else if (tick_1hz) begin
            blink_q <= !blink_q;
          end
        end
        SET_MIN: begin
          if (mode_pulse) begin
            state_q <= RUN;
            blink_q <= 1'b0;
          end else if (tick_1hz) begin
            blink_q <= !blink_q;
          end
        end
        default: begin
          state_q <= RUN;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign hour_one    = hourOne_q;
  assign hour_ten    = hourTen_q;
  assign set_state   = state_q;
  assign blink       = blink_q;
  assign min_strobe  = minStrobe_q;
  assign hour_strobe = hourStrobe_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: an integer time model predicts every cycle's outputs.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       CLR_n;
  logic       tick_1hz;
  logic       mode_pulse;
  logic       inc_pulse;
  logic [3:0] sec_one, sec_ten, min_one, min_ten, hour_one, hour_ten;
  logic [1:0] set_state;
  logic       blink, min_strobe, hour_strobe;

  time_counter #(
    .RESET_HOUR (13),
    .RESET_MIN  (7)
  ) dut (
    .clk         (clk),
    .CLR_n       (CLR_n),
    .tick_1hz    (tick_1hz),
    .mode_pulse  (mode_pulse),
    .inc_pulse   (inc_pulse),
    .sec_one     (sec_one),
    .sec_ten     (sec_ten),
    .min_one     (min_one),
    .min_ten     (min_ten),
    .hour_one    (hour_one),
    .hour_ten    (hour_ten),
    .set_state   (set_state),
    .blink       (blink),
    .min_strobe  (min_strobe),
    .hour_strobe (hour_strobe)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] A_IDLE = 3'b000;
  localparam logic [2:0] A_TICK = 3'b100;
  localparam logic [2:0] A_MODE = 3'b010;
  localparam logic [2:0] A_INC  = 3'b001;

  int checks   = 0;
  int failures = 0;
  int mH, mM, mS, mState, mBlink;
  logic [28:0] sbq[$];

  function automatic logic [28:0] enc(input int h, input int m, input int s,
                                      input int st, input int b, input int ms, input int hs);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            2'(st), 1'(b), 1'(ms), 1'(hs)};
  endfunction

  function automatic logic [28:0] dutVec();
    return {hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one,
            set_state, blink, min_strobe, hour_strobe};
  endfunction

  task automatic modelReset();
    mH = 13; mM = 7; mS = 0; mState = 0; mBlink = 0;
    sbq.delete();
  endtask

  // Advance the model one cycle, queue its prediction, and drive the DUT for that cycle.
  task automatic applyStimulus(input logic [2:0] act);
    logic t, m, i;
    int   ms, hs;
    t = act[2]; m = act[1]; i = act[0];
    ms = 0; hs = 0;
    case (mState)
      0: begin
        if (t) begin
          mS = mS + 1;
          if (mS == 60) begin
            mS = 0; ms = 1; mM = mM + 1;
            if (mM == 60) begin
              mM = 0; hs = 1; mH = (mH + 1) % 24;
            end
          end
        end
        if (m) begin mState = 1; mBlink = 1; end
        else mBlink = 0;
      end
      1: begin
        if (m) begin mState = 2; mBlink = 1; end
        else begin
          if (i) mH = (mH + 1) % 24;
          if (t) mBlink = 1 - mBlink;
        end
      end
      default: begin
        if (m) begin mState = 0; mBlink = 0; mS = 0; end
        else begin
          if (i) mM = (mM + 1) % 60;
          if (t) mBlink = 1 - mBlink;
        end
      end
    endcase
    sbq.push_back(enc(mH, mM, mS, mState, mBlink, ms, hs));
    tick_1hz = t; mode_pulse = m; inc_pulse = i;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] exp;
    CLR_n = 1'b1; tick_1hz = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dutVec() !== enc(13, 7, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h want %h", dutVec(), enc(13, 7, 0, 0, 0, 0, 0));
    end
    CLR_n = 1'b0;
    applyStimulus(A_IDLE);
    exp = sbq.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL reset_idle: got %h want %h", dutVec(), exp);
    end
  endtask

  // Reach h:m:s from RUN through the set mode (seconds restart at 00) followed by ticks.
  task automatic test_preload(input int h, input int m, input int s);
    logic [2:0]  acts[$];
    logic [28:0] exp;
    acts.push_back(A_MODE);
    for (int k = 0; k < (h - mH + 24) % 24; k++) acts.push_back(A_INC);
    acts.push_back(A_MODE);
    for (int k = 0; k < (m - mM + 60) % 60; k++) acts.push_back(A_INC);
    acts.push_back(A_MODE);
    for (int k = 0; k < s; k++) acts.push_back(A_TICK);
    for (int k = 0; k < acts.size(); k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL preload_%0d_%0d_%0d step %0d: got %h want %h", h, m, s, k, dutVec(), exp);
      end
    end
  endtask

  task automatic test_hour_carry();
    logic [28:0] exp;
    logic [28:0] fixedExp [3];
    logic [2:0]  acts [3];
    acts = '{A_TICK, A_TICK, A_IDLE};
    fixedExp = '{enc(12, 59, 59, 0, 0, 0, 0), enc(13, 0, 0, 0, 0, 1, 1), enc(13, 0, 0, 0, 0, 0, 0)};
    test_preload(12, 59, 58);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp || dutVec() !== fixedExp[k]) begin
        failures++;
        $display("[TB] FAIL hour_carry step %0d: got %h want %h", k, dutVec(), fixedExp[k]);
      end
    end
  endtask

  task automatic test_midnight();
    logic [28:0] exp;
    logic [28:0] fixedExp [2];
    logic [2:0]  acts [2];
    acts = '{A_TICK, A_IDLE};
    fixedExp = '{enc(0, 0, 0, 0, 0, 1, 1), enc(0, 0, 0, 0, 0, 0, 0)};
    test_preload(23, 59, 59);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp || dutVec() !== fixedExp[k]) begin
        failures++;
        $display("[TB] FAIL midnight step %0d: got %h want %h", k, dutVec(), fixedExp[k]);
      end
    end
  endtask

  task automatic test_set_mode();
    logic [2:0]  acts[$];
    logic [28:0] exp;
    test_preload(10, 20, 35);
    acts.push_back(A_MODE);
    acts.push_back(A_TICK);
    for (int k = 0; k < 15; k++) begin
      acts.push_back((k == 7) ? (A_INC | A_TICK) : A_INC);
      if (k == 4) acts.push_back(A_TICK);
    end
    acts.push_back(A_MODE);
    acts.push_back(A_TICK);
    for (int k = 0; k < 45; k++) acts.push_back(A_INC);
    acts.push_back(A_TICK);
    acts.push_back(A_TICK);
    acts.push_back(A_MODE);
    for (int k = 0; k < acts.size(); k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL set_mode step %0d: got %h want %h", k, dutVec(), exp);
      end
    end
    checks++;
    if (dutVec() !== enc(1, 5, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL set_mode_final: got %h want %h", dutVec(), enc(1, 5, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0]  acts[$];
    logic [28:0] exp;
    acts.push_back(A_MODE);
    acts.push_back(A_MODE | A_INC);
    acts.push_back(A_MODE);
    acts.push_back(A_INC);
    for (int k = 0; k < 59; k++) acts.push_back(A_TICK);
    for (int k = 0; k < acts.size(); k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL simultaneous step %0d: got %h want %h", k, dutVec(), exp);
      end
    end
    applyStimulus(A_TICK | A_MODE);
    exp = sbq.pop_front();
    checks++;
    if (dutVec() !== exp || dutVec() !== enc(1, 6, 0, 1, 1, 1, 0)) begin
      failures++;
      $display("[TB] FAIL tick_with_mode: got %h want %h", dutVec(), enc(1, 6, 0, 1, 1, 1, 0));
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(A_MODE);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_run step %0d: got %h want %h", k, dutVec(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_adjust();
    logic [2:0]  acts [5];
    logic [28:0] exp;
    acts = '{A_MODE, A_MODE, A_INC, A_INC, A_INC};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(acts[k]);
      exp = sbq.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL adjust step %0d: got %h want %h", k, dutVec(), exp);
      end
    end
    #3;
    CLR_n = 1'b1;
    #1;
    modelReset();
    checks++;
    if (dutVec() !== enc(13, 7, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h want %h", dutVec(), enc(13, 7, 0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    CLR_n = 1'b0;
    applyStimulus(A_TICK);
    exp = sbq.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL after_reset_tick: got %h want %h", dutVec(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_hour_carry();
    test_midnight();
    test_set_mode();
    test_simultaneous();
    test_reset_mid_adjust();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- BCD time-of-day counter feeding the hourly chime stage and the display multiplexer.
- Counts seconds, minutes and hours in 24 h format on a 1 Hz enable tick.
- Provides a two-step manual time-set mode, hour first then minute, driven by pre-debounced single-cycle button pulses.
- Outputs are six BCD digits plus carry strobes; the chime stage consumes all digits directly.

Parameters:
- RESET_HOUR, 0, hour loaded on reset (0..23, stored as two BCD digits)
- RESET_MIN, 0, minute loaded on reset (0..59, stored as two BCD digits)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- CLR_n  input  1  reset, asynchronous, active-high
- tick_1hz  input  1  one-cycle enable pulse, once per second
- mode_pulse  input  1  one-cycle pulse: advance set-mode state
- inc_pulse  input  1  one-cycle pulse: increment field under adjustment
- sec_one  output  4  seconds units BCD 0..9
- sec_ten  output  4  seconds tens BCD 0..5
- min_one  output  4  minutes units BCD 0..9
- min_ten  output  4  minutes tens BCD 0..5
- hour_one  output  4  hours units BCD 0..9 (0..3 when hour_ten=2)
- hour_ten  output  4  hours tens BCD 0..2
- set_state  output  2  00=RUN, 01=SET_HOUR, 10=SET_MIN
- blink  output  1  display blink for the field being adjusted
- min_strobe  output  1  one-cycle pulse when seconds wrap 59->00 in RUN
- hour_strobe  output  1  one-cycle pulse when minutes wrap 59->00 in RUN

Behaviour:
- Reset (CLR_n=1, asynchronous):
  - seconds=00; minutes=RESET_MIN; hours=RESET_HOUR.
  - set_state=RUN; blink=0; strobes=0.
  - Reset mid-adjust returns to RUN immediately and discards the partial edit.
- FSM, advanced only by mode_pulse:
  - RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Leaving SET_MIN clears seconds to 00 in that same edge; minutes and hours are kept.
- RUN:
  - On tick_1hz, sec_one increments.
  - 9->0 carries into sec_ten; sec_ten 5->0 carries into minutes. The same chain applies to minutes and into hours.
  - Hours wrap 23->00; no carry out of hours.
  - Each update completes in the edge of the tick, with no multi-cycle ripple.
  - min_strobe and hour_strobe are asserted for the same single cycle in which the wrapped value appears.
  - Rollover 23:59:59 -> 00:00:00 asserts both strobes.
  - inc_pulse is ignored.
- SET_HOUR:
  - Time-keeping is paused and tick_1hz does not advance seconds.
  - inc_pulse increments hours mod 24 (23->00), with no effect on other fields.
- SET_MIN:
  - Time-keeping stays paused.
  - inc_pulse increments minutes mod 60 (59->00); there is no carry into hours.
- blink:
  - 0 in RUN.
  - In the set states, blink toggles on every tick_1hz and is forced to 1 on entry to each set state.
- Strobes are never asserted outside RUN.
- Simultaneous events:
  - mode_pulse together with inc_pulse: the mode transition wins and inc_pulse is dropped.
  - tick_1hz together with mode_pulse in RUN: the tick is applied first, then the state changes. The strobes from that tick are still emitted.
  - tick_1hz together with inc_pulse in a set state: the increment is applied.
- Invariants:
  - Outputs are registered and never show non-BCD codes or out-of-range values such as 24:xx or x:60.
  - An out-of-range parameter is a synthesis-time error (assertion in the parameter check).

Decomposition:
- Shared package clock_pkg holds:
  - state encoding constants RUN/SET_HOUR/SET_MIN;
  - BCD limits SEC_TEN_MAX=5, MIN_TEN_MAX=5, HOUR_MAX_TEN=2, HOUR_MAX_ONE_AT_TEN2=3.
- One sub-module, bcd_mod60: two-digit BCD counter with enable, synchronous clear and a carry-out pulse.
  - Instantiated twice, once for seconds and once for minutes.
- The hour counter (mod 24) stays inline in time_counter.

Test Plan:
- Reset with RESET_HOUR=13, RESET_MIN=7 -> outputs 13:07:00, set_state=00, blink=0, strobes=0.
- Preload 12:59:58 and apply 2 ticks -> 12:59:59, then 13:00:00. Both strobes pulse exactly once, in the cycle showing 13:00:00.
- Preload 23:59:59 and apply 1 tick -> 00:00:00, both strobes high for one cycle, and the digit bus never shows 24.
- Mode sequence from 10:20:35:
  - mode, then 15 inc -> hours show 01 (wrapped through 23->00).
  - mode, then 45 inc -> minutes 05, hours unchanged.
  - mode -> 01:05:00, RUN.
  - Ticks during the set states leave the time unchanged, and blink toggles on each tick.
- Same-cycle mode_pulse+inc_pulse in SET_HOUR -> state becomes SET_MIN and hours are unchanged. Same-cycle tick+mode in RUN at xx:xx:59 -> seconds wrap, min_strobe pulses, state becomes SET_HOUR.
- Assert CLR_n in SET_MIN after 3 inc -> immediate return to RESET_HOUR:RESET_MIN:00 and RUN, without waiting for a clock edge.
